// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Purpose  : Shared seven-segment definitions for the scan decoder and the
//            display driver's encoder. Glyphs are active-low, {g,f,e,d,c,b,a}.
// Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

  // Number of multiplexed digit positions on the display bus
  localparam int c_num_digits = 4;

  // Glyph patterns, 0 = segment lit
  localparam logic [6:0] c_glyph_0     = 7'h40;
  localparam logic [6:0] c_glyph_1     = 7'h79;
  localparam logic [6:0] c_glyph_2     = 7'h24;
  localparam logic [6:0] c_glyph_3     = 7'h30;
  localparam logic [6:0] c_glyph_4     = 7'h19;
  localparam logic [6:0] c_glyph_5     = 7'h12;
  localparam logic [6:0] c_glyph_6     = 7'h02;
  localparam logic [6:0] c_glyph_7     = 7'h78;
  localparam logic [6:0] c_glyph_8     = 7'h00;
  localparam logic [6:0] c_glyph_9     = 7'h10;
  localparam logic [6:0] c_glyph_a     = 7'h08;
  localparam logic [6:0] c_glyph_b     = 7'h03;
  localparam logic [6:0] c_glyph_c     = 7'h46;
  localparam logic [6:0] c_glyph_d     = 7'h21;
  localparam logic [6:0] c_glyph_e     = 7'h06;
  localparam logic [6:0] c_glyph_f     = 7'h0E;
  localparam logic [6:0] c_glyph_blank = 7'h7F;

  // One decoded digit: binary value plus undecodable flag
  typedef struct packed {
    logic       err;
    logic [3:0] val;
  } digit_t;

  // Value-to-glyph mapping used by the display driver's encoder
  function automatic logic [6:0] glyph_encode(input logic [3:0] v);
    case (v)
      4'h0:    return c_glyph_0;
      4'h1:    return c_glyph_1;
      4'h2:    return c_glyph_2;
      4'h3:    return c_glyph_3;
      4'h4:    return c_glyph_4;
      4'h5:    return c_glyph_5;
      4'h6:    return c_glyph_6;
      4'h7:    return c_glyph_7;
      4'h8:    return c_glyph_8;
      4'h9:    return c_glyph_9;
      4'hA:    return c_glyph_a;
      4'hB:    return c_glyph_b;
      4'hC:    return c_glyph_c;
      4'hD:    return c_glyph_d;
      4'hE:    return c_glyph_e;
      default: return c_glyph_f;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_glyph_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg_glyph_decode
// Purpose  : Combinational glyph-to-digit decode. Unknown patterns return
//            value 0 with the error flag set.
// Config   : SEG_SCAN_HEX_EN - when defined, glyphs A..F decode to 10..15;
//            otherwise they are undecodable (BCD-only build).
// Revision : 1.0 - initial release
// ============================================================================
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output digit_t     digit
);

  // Pattern match against the shared glyph table; anything unmatched is an error
  always_comb begin
    digit = '{err: 1'b1, val: 4'h0};
    case (seg)
      c_glyph_0: digit = '{err: 1'b0, val: 4'h0};
      c_glyph_1: digit = '{err: 1'b0, val: 4'h1};
      c_glyph_2: digit = '{err: 1'b0, val: 4'h2};
      c_glyph_3: digit = '{err: 1'b0, val: 4'h3};
      c_glyph_4: digit = '{err: 1'b0, val: 4'h4};
      c_glyph_5: digit = '{err: 1'b0, val: 4'h5};
      c_glyph_6: digit = '{err: 1'b0, val: 4'h6};
      c_glyph_7: digit = '{err: 1'b0, val: 4'h7};
      c_glyph_8: digit = '{err: 1'b0, val: 4'h8};
      c_glyph_9: digit = '{err: 1'b0, val: 4'h9};
`ifdef SEG_SCAN_HEX_EN
      c_glyph_a: digit = '{err: 1'b0, val: 4'hA};
      c_glyph_b: digit = '{err: 1'b0, val: 4'hB};
      c_glyph_c: digit = '{err: 1'b0, val: 4'hC};
      c_glyph_d: digit = '{err: 1'b0, val: 4'hD};
      c_glyph_e: digit = '{err: 1'b0, val: 4'hE};
      c_glyph_f: digit = '{err: 1'b0, val: 4'hF};
`endif
      default:   digit = '{err: 1'b1, val: 4'h0};
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_decoder
// Purpose  : Samples a multiplexed seven-segment seg/an bus and rebuilds the
//            four displayed digits. Flags collisions, bad glyphs and a
//            stalled scan.
// Config   : SEG_SCAN_HEX_EN (in seg_glyph_decode) enables A..F decoding.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1048576
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        collision,
  output logic        stale
);

  localparam int              c_tw      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]      c_stable  = 8'(STABLE_CYCLES);
  localparam logic [c_tw-1:0] c_timeout = c_tw'(TIMEOUT_CYCLES);

  // Sample stage and the previous sample it is compared against
  logic [6:0] r_seg, r_seg_prev;
  logic [3:0] r_an, r_an_prev;

  // Dwell tracking
  logic [7:0] r_dwell;
  logic       r_armed;

  // Pending frame
  digit_t     r_pend [c_num_digits];
  logic [3:0] r_pend_mask;

  // Committed frame and status
  logic [15:0]     r_digits;
  logic [3:0]      r_digit_err;
  logic            r_frame_valid;
  logic [c_tw-1:0] r_tcnt;
  logic            r_stale;

  // Combinational decisions
  logic [3:0]  w_an_lo;
  logic [3:0]  w_an_dup;
  logic        w_multi;
  logic        w_single;
  logic        w_same;
  logic [7:0]  w_dwell_inc;
  logic [7:0]  w_dwell_next;
  logic        w_capture;
  logic        w_commit;
  logic [3:0]  w_cap_mask;
  digit_t      w_decoded;
  logic [15:0] w_frame_val;
  logic [3:0]  w_frame_err;

  seg_glyph_decode u_decode (
    .seg   (r_seg),
    .digit (w_decoded)
  );

  // Anode classification: clearing the lowest set bit leaves residue only
  // when two or more anodes are active
  assign w_an_lo  = ~r_an;
  assign w_an_dup = w_an_lo & (w_an_lo - 4'd1);
  assign w_multi  = |w_an_dup;
  assign w_single = (|w_an_lo) & ~w_multi;

  assign w_same      = (r_seg == r_seg_prev) && (r_an == r_an_prev);
  assign w_dwell_inc = (r_dwell >= c_stable) ? c_stable : (r_dwell + 8'd1);
  // A collision restarts the dwell so it can never build toward a capture
  assign w_dwell_next = w_multi ? 8'd0 : (w_same ? w_dwell_inc : 8'd1);

  assign w_capture = r_armed & w_single & (w_dwell_next == c_stable);
  assign w_commit  = (r_pend_mask == 4'hF);

  // Capture target is the single active anode
  for (genvar gi = 0; gi < c_num_digits; gi++) begin : g_cap_mask
    assign w_cap_mask[gi] = w_capture & w_an_lo[gi];
  end

  // Collision reported once, on the first sample of the offending pattern
  assign collision = w_multi & ~w_same;

  // Flatten the pending slots into the output layout
  always_comb begin
    w_frame_val = '0;
    w_frame_err = '0;
    for (int i = 0; i < c_num_digits; i++) begin
      w_frame_val[4*i +: 4] = r_pend[i].val;
      w_frame_err[i]        = r_pend[i].err;
    end
  end

  // Input sample register and one-deep history for stability comparison
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seg      <= c_glyph_blank;
      r_an       <= 4'hF;
      r_seg_prev <= c_glyph_blank;
      r_an_prev  <= 4'hF;
    end else begin
      r_seg      <= seg;
      r_an       <= an;
      r_seg_prev <= r_seg;
      r_an_prev  <= r_an;
    end
  end

  // Dwell counter and one-capture-per-dwell arming
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dwell <= 8'd0;
      r_armed <= 1'b1;
    end else begin
      r_dwell <= w_dwell_next;
      if (!w_same) begin
        r_armed <= 1'b1;
      end else if (w_capture) begin
        r_armed <= 1'b0;
      end
    end
  end

  // Pending slots; newest capture overwrites, and a capture coinciding with
  // a commit starts the next frame's mask
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_mask <= 4'h0;
      for (int i = 0; i < c_num_digits; i++) begin
        r_pend[i] <= '0;
      end
    end else begin
      for (int i = 0; i < c_num_digits; i++) begin
        if (w_cap_mask[i]) begin
          r_pend[i] <= w_decoded;
        end
      end
      if (w_commit) begin
        r_pend_mask <= w_cap_mask;
      end else begin
        r_pend_mask <= r_pend_mask | w_cap_mask;
      end
    end
  end

  // Frame commit: publish the completed pending set for one cycle pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_digits      <= 16'h0000;
      r_digit_err   <= 4'h0;
      r_frame_valid <= 1'b0;
    end else begin
      r_frame_valid <= w_commit;
      if (w_commit) begin
        r_digits    <= w_frame_val;
        r_digit_err <= w_frame_err;
      end
    end
  end

  // Scan-stall watchdog: saturating counter cleared by any capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tcnt  <= '0;
      r_stale <= 1'b0;
    end else if (w_capture) begin
      r_tcnt  <= '0;
      r_stale <= 1'b0;
    end else begin
      if (r_tcnt != c_timeout) begin
        r_tcnt <= r_tcnt + c_tw'(1);
      end
      if (r_tcnt == c_timeout) begin
        r_stale <= 1'b1;
      end
    end
  end

  assign digits      = r_digits;
  assign digit_err   = r_digit_err;
  assign frame_valid = r_frame_valid;
  assign stale       = r_stale;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_seg_scan_decoder
// Purpose  : Self-checking bench for seg_scan_decoder: table of full-frame
//            scans plus hand sequences for dwell, collision, stale and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_decoder;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 64;
  localparam int DWELL   = 8;
  localparam int NVEC    = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  an  = 4'hF;
  logic [15:0] digits;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        collision;
  logic        stale;

  seg_scan_decoder #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg         (seg),
    .an          (an),
    .digits      (digits),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .collision   (collision),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  err;
  } frame_t;

  typedef struct packed {
    logic [27:0] glyphs;   // {d3,d2,d1,d0}
    logic [15:0] digits;
    logic [3:0]  err;
  } vec_t;

  frame_t sb_q[$];
  frame_t exp_f;
  vec_t   vecs [NVEC];
  int     n_vec = 0;
  int     n_err = 0;
  int     n_fv  = 0;
  int     n_col = 0;

  // Output monitor: every frame_valid pops one expected frame
  always @(negedge clk) begin
    if (collision) n_col++;
    if (frame_valid) begin
      n_fv++;
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL frame_unexpected: got digits=%h err=%b, required no frame", digits, digit_err);
      end else begin
        exp_f = sb_q.pop_front();
        if ({digits, digit_err} !== exp_f) begin
          n_err++;
          $display("FAIL frame: got digits=%h err=%b, required digits=%h err=%b",
                   digits, digit_err, exp_f.digits, exp_f.err);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic hold(input logic [6:0] s, input logic [3:0] a, input int n);
    seg = s;
    an  = a;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [27:0] g);
    for (int i = 0; i < 4; i++) begin
      hold(g[7*i +: 7], 4'(~(4'b0001 << i)), DWELL);
      hold(7'h7F, 4'hF, 2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fv0;

    vecs[0] = '{glyphs: {7'h40, 7'h79, 7'h24, 7'h30}, digits: 16'h0123, err: 4'b0000};
    vecs[1] = '{glyphs: {7'h78, 7'h02, 7'h12, 7'h19}, digits: 16'h7654, err: 4'b0000};
    vecs[2] = '{glyphs: {7'h79, 7'h40, 7'h10, 7'h00}, digits: 16'h1098, err: 4'b0000};
    vecs[3] = '{glyphs: {7'h40, 7'h79, 7'h7F, 7'h30}, digits: 16'h0103, err: 4'b0010};
    vecs[5] = '{glyphs: {7'h7E, 7'h19, 7'h02, 7'h10}, digits: 16'h0469, err: 4'b1000};
`ifdef SEG_SCAN_HEX_EN
    vecs[4] = '{glyphs: {7'h0E, 7'h08, 7'h00, 7'h10}, digits: 16'hFA89, err: 4'b0000};
    vecs[6] = '{glyphs: {7'h06, 7'h21, 7'h46, 7'h03}, digits: 16'hEDCB, err: 4'b0000};
`else
    vecs[4] = '{glyphs: {7'h0E, 7'h08, 7'h00, 7'h10}, digits: 16'h0089, err: 4'b1100};
    vecs[6] = '{glyphs: {7'h06, 7'h21, 7'h46, 7'h03}, digits: 16'h0000, err: 4'b1111};
`endif

    // Reset state
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {9'b0, digits, digit_err, frame_valid, collision, stale}, 32'h0);
    rst = 1'b1;
    hold(7'h7F, 4'hF, 2);

    // Collision: pulse one cycle after the input, no capture
    fv0 = n_fv;
    hold(7'h40, 4'b1100, 1);
    check("collision_pulse", {31'b0, collision}, 32'h1);
    hold(7'h40, 4'b1100, DWELL - 1);
    check("collision_count", n_col, 1);
    hold(7'h7F, 4'hF, 3);
    check("collision_no_frame", n_fv - fv0, 0);

    // Table of full scans
    fv0 = n_fv;
    for (int v = 0; v < NVEC; v++) begin
      sb_q.push_back({vecs[v].digits, vecs[v].err});
      scan(vecs[v].glyphs);
      hold(7'h7F, 4'hF, 3);
    end
    check("table_frames", n_fv - fv0, NVEC);

    // Short dwell on slot 2 leaves the frame incomplete
    fv0 = n_fv;
    hold(7'h19, 4'b1110, DWELL); hold(7'h7F, 4'hF, 2);
    hold(7'h12, 4'b1101, DWELL); hold(7'h7F, 4'hF, 2);
    hold(7'h02, 4'b1011, STABLE - 1); hold(7'h7F, 4'hF, 5);
    hold(7'h78, 4'b0111, DWELL); hold(7'h7F, 4'hF, 2);
    check("short_dwell_no_frame", n_fv - fv0, 0);
    // Re-capture slot 0 (newest wins), then fill slot 2
    hold(7'h40, 4'b1110, DWELL); hold(7'h7F, 4'hF, 2);
    sb_q.push_back({16'h7250, 4'b0000});
    hold(7'h24, 4'b1011, DWELL);

    // Stale after a long blank, digits held, cleared by the next capture
    hold(7'h7F, 4'hF, 40);
    check("stale_low_early", {31'b0, stale}, 32'h0);
    hold(7'h7F, 4'hF, 40);
    check("stale_high", {31'b0, stale}, 32'h1);
    check("stale_digits_held", {16'b0, digits}, 32'h7250);
    hold(7'h30, 4'b1110, 2);
    check("stale_before_capture", {31'b0, stale}, 32'h1);
    hold(7'h30, 4'b1110, DWELL - 2);
    check("stale_cleared", {31'b0, stale}, 32'h0);
    hold(7'h7F, 4'hF, 2);
    hold(7'h24, 4'b1101, DWELL); hold(7'h7F, 4'hF, 2);
    hold(7'h79, 4'b1011, DWELL); hold(7'h7F, 4'hF, 2);
    sb_q.push_back({16'h0123, 4'b0000});
    hold(7'h40, 4'b0111, DWELL); hold(7'h7F, 4'hF, 4);

    // Asynchronous reset after three captures
    hold(7'h79, 4'b1110, DWELL); hold(7'h7F, 4'hF, 2);
    hold(7'h24, 4'b1101, DWELL); hold(7'h7F, 4'hF, 2);
    hold(7'h30, 4'b1011, DWELL);
    #2 rst = 1'b0;
    #1 check("async_reset", {9'b0, digits, digit_err, frame_valid, collision, stale}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    fv0 = n_fv;
    hold(7'h19, 4'b0111, DWELL); hold(7'h7F, 4'hF, 4);
    check("reset_cleared_pending", n_fv - fv0, 0);
    hold(7'h12, 4'b1110, DWELL); hold(7'h7F, 4'hF, 2);
    hold(7'h02, 4'b1101, DWELL); hold(7'h7F, 4'hF, 2);
    sb_q.push_back({16'h4765, 4'b0000});
    hold(7'h78, 4'b1011, DWELL); hold(7'h7F, 4'hF, 10);

    check("scoreboard_empty", sb_q.size(), 0);
    check("total_frames", n_fv, NVEC + 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart to the multiplexed seven-segment display driver. Samples the scanned `seg`/`an` bus and reconstructs the four displayed hex digits as binary values. Used as an on-chip loopback monitor and as a scoreboard probe for the clock/stopwatch top level. Also flags scan collisions, undecodable glyphs and a stalled scan.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a digit is captured; legal range 2..255.
- `TIMEOUT_CYCLES`, default 1048576: cycles without any capture before `stale` asserts; must be at least 4·`STABLE_CYCLES`.

Ports:
- `clk` input 1: system clock (100 MHz).
- `rst` input 1: reset, asynchronous, active-low.
- `seg` input 7: segment bus `{g,f,e,d,c,b,a}`, active-low (0 = lit); synchronous to `clk`.
- `an` input 4: anode bus, active-low; `an[i]` low selects digit i, where digit 0 is the rightmost.
- `digits` output 16: decoded frame; digit i occupies bits `[4i+3:4i]`.
- `digit_err` output 4: bit i set means digit i of the current frame was undecodable.
- `frame_valid` output 1: one-cycle pulse when `digits`/`digit_err` update.
- `collision` output 1: one-cycle pulse when more than one anode is low in a registered sample.
- `stale` output 1: level; no capture for `TIMEOUT_CYCLES` cycles.

## Operation
- **Input stage:** `seg` and `an` are registered once (sample stage) before any decision.
- **Dwell tracking:** compare the current sample with the previous sample. If they are equal, increment the dwell counter, saturating at `STABLE_CYCLES`. If they differ, reset the counter to 1 and re-arm capture.
- **Capture:** when the dwell counter reaches `STABLE_CYCLES`, capture is armed, and exactly one anode is low at index i, then:
  - decode the sample's `seg` into the pending slot i (4-bit value plus error bit);
  - set pending-mask bit i;
  - disarm capture for the rest of this dwell. Exactly one capture per dwell.
- **Blank** (all anodes high): never captured. Does not clear the pending mask.
- **Collision** (two or more anodes low): pulse `collision` and reset the dwell counter. No capture.
- **Glyph decode:** 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10→9. Hex letters A–F (0x08, 0x03, 0x46, 0x21, 0x06, 0x0E) are governed by the configuration macro below. Any other pattern sets the error bit and stores value 0.
- **Frame completion:** when the pending mask becomes 4'b1111:
  - on the next cycle, copy the pending slots to `digits`/`digit_err` and pulse `frame_valid`;
  - clear the pending mask in that same cycle.
- **Re-capture before frame:** recapturing an already-pending slot overwrites it, newest wins.
- **Simultaneous events:** a capture in the same cycle as a frame commit is credited to the new frame (mask becomes that single bit).
- **Stale:**
  - The timeout counter resets on every capture.
  - `stale` asserts when the counter reaches `TIMEOUT_CYCLES`; the counter then saturates.
  - `stale` deasserts on the cycle after the next capture.
  - `digits` hold their last value throughout.
- **Reset:** asynchronous, mid-operation allowed. Reset values:
  - `digits` = 0, `digit_err` = 0, `frame_valid` = 0, `collision` = 0, `stale` = 0;
  - pending mask = 0, dwell counter = 0, capture armed, timeout counter = 0.

## Timing
- Sample register: 1 cycle.
- Capture happens in the cycle the `STABLE_CYCLES`-th identical sample is present, i.e. `STABLE_CYCLES` cycles after the input change.
- `frame_valid` is asserted 1 cycle after the fourth-slot capture.
- Minimum latency from the last digit's input change to `frame_valid`: `STABLE_CYCLES`+2 cycles.
- A dwell shorter than `STABLE_CYCLES` is ignored. This covers scan-transition glitches and ghosting.
- `collision` is asserted 1 cycle after the offending input.

## Configuration
- Macro `SEG_SCAN_HEX_EN`.
- Defined: A–F glyphs decode to 10–15.
- Undefined: those glyphs are treated as undecodable (error bit set, value 0). This is the BCD-only build for the clock display.

## Structure
- Shared package `seg_pkg` holds:
  - the glyph constants (active-low, gfedcba order) for 0–F;
  - the digit count (4);
  - an enum/typedef for the 4-bit digit with its error bit.
- The display driver's encoder reuses the same constants.
- One sub-module, `seg_glyph_decode`: combinational 7-bit→{4-bit value, err}. It carries the `SEG_SCAN_HEX_EN` guard.
- The top module holds the sample register, dwell/arm logic, pending slots, frame commit and timeout counter.

## Test plan
- **Steady frame:** scan an = 1110/1101/1011/0111 with seg 0x30/0x24/0x79/0x40, 8 cycles each → `frame_valid` pulse, `digits` = 16'h0123, `digit_err` = 0.
- **Short dwell:** with `STABLE_CYCLES`=4, present digit 2 for 3 cycles, then blank → no capture; `frame_valid` absent after a full scan missing slot 2.
- **Collision and bad glyph:** drive an = 1100 for 8 cycles → `collision` pulse, no capture. Then a full scan with digit 1 = 0x7F (all off) → `digit_err` = 4'b0010, digit 1 = 0.
- **Hex build:** scan glyphs 0x0E/0x08/0x00/0x10 → with `SEG_SCAN_HEX_EN`, `digits` = 16'hFA89 and `digit_err` = 0; without it, `digit_err` = 4'b1100.
- **Stale:** with `TIMEOUT_CYCLES`=64, hold blank for 70 cycles → `stale` high at cycle 64+1; the next valid capture clears it.
- **Reset:** assert reset mid-scan after 3 captures → all outputs 0 asynchronously. After release, a fresh full scan is needed before `frame_valid`.
